// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: opcodes, format and FSM enums.
package instr_encoder_pkg;

    localparam logic [6:0] OPC_R = 7'b0000001;
    localparam logic [6:0] OPC_I = 7'b0000011;
    localparam logic [6:0] OPC_U = 7'b0000111;
    localparam logic [6:0] OPC_B = 7'b0001111;

    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_U = 2'd2,
        FMT_B = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_ERR   = 2'd2
    } state_e;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-input handshake plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        fmt;
    logic [3:0]        func;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [31:0]       imm;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              hata;

    modport slave (
        input  in_valid, fmt, func, rs1, rs2, rd, imm,
        output in_ready, imem_we, imem_addr, imem_wdata, count, full, hata
    );

    modport master (
        output in_valid, fmt, func, rs1, rs2, rd, imm,
        input  in_ready, imem_we, imem_addr, imem_wdata, count, full, hata
    );
endinterface

// File: rtl/instr_pack.sv
// Combinational field-to-word encoder with per-format legality check.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  fmt_e        fmt,
    input  logic [3:0]  func,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [4:0]  rd,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    // Assemble the word for the selected format and flag out-of-range fields.
    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (fmt)
            FMT_R: begin
                word = {1'b0, func[3], 5'b0, rs2, rs1, func[2:0], rd, OPC_R};
            end
            FMT_I: begin
                word    = {imm[11:0], rs1, func[2:0], rd, OPC_I};
                illegal = func[3] | (|imm[31:12]);
            end
            FMT_U: begin
                word    = {imm[19:0], rd, OPC_U};
                illegal = |imm[31:20];
            end
            FMT_B: begin
                word    = {imm[12:6], rs2, rs1, func[2:0], imm[5:1], OPC_B};
                illegal = func[3] | imm[0] | (|imm[31:13]);
            end
            default: begin
                word    = '0;
                illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Accepts instruction fields, encodes them and writes them sequentially into
// instruction memory; illegal instructions raise a one-cycle hata pulse.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    instr_encoder_if.slave  bus
);

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

    state_e            state_reg;
    logic [ADDR_W:0]   count_reg;
    logic              we_reg;
    logic              hata_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;

    logic              full;
    logic              ready;
    logic              accept;
    logic [31:0]       word;
    logic              illegal;

    assign full   = (count_reg == DEPTH_C);
    assign ready  = (state_reg == ST_IDLE) && !full;
    assign accept = bus.in_valid && ready;

    instr_pack u_pack (
        .fmt     (fmt_e'(bus.fmt)),
        .func    (bus.func),
        .rs1     (bus.rs1),
        .rs2     (bus.rs2),
        .rd      (bus.rd),
        .imm     (bus.imm),
        .word    (word),
        .illegal (illegal)
    );

    // FSM, counter and registered write port; the fields are captured at
    // acceptance already in encoded form, so the write data is a plain register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            count_reg <= '0;
            we_reg    <= 1'b0;
            hata_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            we_reg    <= 1'b0;
            hata_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        if (illegal) begin
                            state_reg <= ST_ERR;
                            hata_reg  <= 1'b1;
                        end else begin
                            state_reg <= ST_WRITE;
                            we_reg    <= 1'b1;
                            // A simultaneous clear restarts the address too.
                            addr_reg  <= clear ? '0 : count_reg[ADDR_W-1:0];
                            wdata_reg <= word;
                        end
                    end
                end
                ST_WRITE: state_reg <= ST_IDLE;
                ST_ERR:   state_reg <= ST_IDLE;
                default:  state_reg <= ST_IDLE;
            endcase
            // clear wins over the end-of-write increment.
            if (clear) begin
                count_reg <= '0;
            end else if (state_reg == ST_WRITE) begin
                count_reg <= count_reg + (ADDR_W+1)'(1);
            end
        end
    end

    assign bus.in_ready   = ready;
    assign bus.imem_we    = we_reg;
    assign bus.imem_addr  = addr_reg;
    assign bus.imem_wdata = wdata_reg;
    assign bus.count      = count_reg;
    assign bus.full       = full;
    assign bus.hata       = hata_reg;

endmodule
